// File: rtl/alu_pipe_n_bit.sv
// alu_pipe_n_bit: two-stage WIDTH-bit ALU built from 4-bit lookahead groups with a second-level group lookahead,
// valid/ready handshakes on both sides and zero/negative/overflow/carry status flags.
module alu_pipe_n_bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);
  localparam int NG = WIDTH / 4;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  logic             s1_valid, ld2, in_fire, sub_op, c_eff;
  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic [NG-1:0]    gp_in, gg_in;
  logic [WIDTH-1:0] s1_a, s1_b, s1_p, s1_g;
  logic [NG-1:0]    s1_gp, s1_gg;
  logic             s1_c;
  logic [2:0]       s1_op;
  logic [NG:0]      gc;
  logic [WIDTH:0]   cy;
  logic             acc, term, ovf, slt_bit, arith;
  logic [WIDTH-1:0] sum, res_d;
  assign ld2      = !out_valid || out_ready;
  assign in_ready = !s1_valid || ld2;
  assign in_fire  = in_valid && in_ready;
  assign sub_op   = alu_op == OP_SUB || alu_op == OP_SLT;
  assign b_eff    = sub_op ? ~b : b;
  assign c_eff    = sub_op || (alu_op == OP_ADD && c_in);
  assign p_in     = a | b_eff;
  assign g_in     = a & b_eff;
  always_comb begin
    gp_in = '0;
    gg_in = '0;
    for (int k = 0; k < NG; k++) begin
      gp_in[k] = &p_in[4*k +: 4];
      gg_in[k] = g_in[4*k+3] | (p_in[4*k+3] & g_in[4*k+2]) | (&p_in[4*k+2 +: 2] & g_in[4*k+1]) |
                 (&p_in[4*k+1 +: 3] & g_in[4*k]);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (in_fire) s1_valid <= 1'b1;
    else if (ld2) s1_valid <= 1'b0;
    if (in_fire) begin
      s1_a  <= a;
      s1_b  <= b_eff;
      s1_c  <= c_eff;
      s1_op <= alu_op;
      s1_p  <= p_in;
      s1_g  <= g_in;
      s1_gp <= gp_in;
      s1_gg <= gg_in;
    end
  end
  // Both levels are flat sum-of-products: carry = cin & P[0..n-1] | OR_j G[j] & P[j+1..n-1]
  always_comb begin
    gc   = '0;
    cy   = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      acc = s1_c;
      for (int j = 0; j < k; j++) acc = acc & s1_gp[j];
      for (int j = 0; j < k; j++) begin
        term = s1_gg[j];
        for (int m = j + 1; m < k; m++) term = term & s1_gp[m];
        acc = acc | term;
      end
      gc[k] = acc;
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        acc = gc[k];
        for (int j = 0; j < i; j++) acc = acc & s1_p[4*k+j];
        for (int j = 0; j < i; j++) begin
          term = s1_g[4*k+j];
          for (int m = j + 1; m < i; m++) term = term & s1_p[4*k+m];
          acc = acc | term;
        end
        cy[4*k+i] = acc;
      end
    end
    cy[WIDTH] = gc[NG];
  end
  assign sum     = s1_a ^ s1_b ^ cy[WIDTH-1:0];
  assign ovf     = cy[WIDTH-1] ^ cy[WIDTH];
  assign slt_bit = sum[WIDTH-1] ^ ovf;
  assign arith   = s1_op == OP_ADD || s1_op == OP_SUB || s1_op == OP_SLT;
  assign res_d   = s1_op == OP_AND ? s1_g :
                   s1_op == OP_OR  ? s1_p :
                   s1_op == OP_XOR ? s1_a ^ s1_b :
                   s1_op == OP_NOR ? ~s1_p :
                   s1_op == OP_SLT ? {{(WIDTH-1){1'b0}}, slt_bit} :
                   arith           ? sum : s1_b;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else if (ld2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= res_d;
        c_out    <= arith && cy[WIDTH];
        zero     <= res_d == '0;
        negative <= res_d[WIDTH-1];
        overflow <= (s1_op == OP_ADD || s1_op == OP_SUB) && ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe_n_bit.sv
// tb_alu_pipe_n_bit: scoreboard bench for the pipelined ALU; a monitor compares every output transfer
// against a behavioural model, scenario tasks check latency, throughput, stalls and reset.
module tb_alu_pipe_n_bit;
  typedef struct packed {logic [15:0] r; logic c, z, n, v;} exp_t;
  typedef struct packed {logic [2:0] op; logic [15:0] x, y; logic ci;} stim_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, c_in = 0, out_valid, out_ready = 1, c_out, zero, negative, overflow;
  logic [15:0] a = '0, b = '0, result;
  logic [2:0] alu_op = '0;
  logic v4_in = 0, v4_rdy, v4_out, v4_c, v4_z, v4_n, v4_v;
  logic [3:0] a4 = '0, b4 = '0, r4;
  logic v32_in = 0, v32_rdy, v32_out, v32_c, v32_z, v32_n, v32_v;
  logic [31:0] a32 = '0, b32 = '0, r32;
  exp_t sb[$];
  exp_t exp_e;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_pipe_n_bit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
    .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready), .result(result), .c_out(c_out),
    .zero(zero), .negative(negative), .overflow(overflow)
  );
  alu_pipe_n_bit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_in), .in_ready(v4_rdy), .a(a4), .b(b4), .c_in(1'b0),
    .alu_op(3'b010), .out_valid(v4_out), .out_ready(1'b1), .result(r4), .c_out(v4_c),
    .zero(v4_z), .negative(v4_n), .overflow(v4_v)
  );
  alu_pipe_n_bit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32_in), .in_ready(v32_rdy), .a(a32), .b(b32), .c_in(1'b0),
    .alu_op(3'b010), .out_valid(v32_out), .out_ready(1'b1), .result(r32), .c_out(v32_c),
    .zero(v32_z), .negative(v32_n), .overflow(v32_v)
  );
  function automatic exp_t model(input logic [15:0] x, y, input logic ci, input logic [2:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y} + {16'b0, ci};
        r = s[15:0];
        c = s[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      3'b011: r = x ^ y;
      3'b100: r = ~(x | y);
      3'b101: begin
        r = x - y;
        c = x >= y;
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      3'b110: begin
        r = {15'b0, $signed(x) < $signed(y)};
        c = x >= y;
      end
      default: r = y;
    endcase
    return {r, c, r == 16'h0, r[15], v};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: unexpected output result=%h with nothing expected", result);
        end else begin
          exp_e = sb.pop_front();
          if ({result, c_out, zero, negative, overflow} !== exp_e) begin
            n_fail++;
            $display("FAIL scoreboard: got r=%h c=%b z=%b n=%b v=%b, expected r=%h c=%b z=%b n=%b v=%b",
                     result, c_out, zero, negative, overflow, exp_e.r, exp_e.c, exp_e.z, exp_e.n, exp_e.v);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, c_in, alu_op));
    end
  end
  task automatic send(input logic [2:0] op, input logic [15:0] x, y, input logic ci);
    in_valid = 1'b1;
    alu_op = op;
    a = x;
    b = y;
    c_in = ci;
  endtask
  task automatic test_reset;
    rst_n = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
    n_checks++;
    if ({c_out, zero, negative, overflow} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {c_out, zero, negative, overflow});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask
  task automatic test_latency;
    @(posedge clk); #1 send(3'b010, 16'h00FF, 16'h0001, 1'b0);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if ({out_valid, result, c_out, zero, overflow} !== {1'b1, 16'h0100, 3'b000}) begin
      n_fail++;
      $display("FAIL latency_add: got v=%b r=%h c=%b z=%b o=%b expected v=1 r=0100 c=0 z=0 o=0",
               out_valid, result, c_out, zero, overflow);
    end
    repeat (2) @(posedge clk);
  endtask
  task automatic test_ops;
    stim_t tbl[11] = '{
      '{3'b010, 16'h7FFF, 16'h0001, 1'b0}, '{3'b101, 16'h0005, 16'h0005, 1'b1},
      '{3'b110, 16'hFFFE, 16'h0003, 1'b0}, '{3'b110, 16'h0003, 16'hFFFE, 1'b0},
      '{3'b000, 16'hF0F0, 16'hFF00, 1'b0}, '{3'b001, 16'hF0F0, 16'hFF00, 1'b0},
      '{3'b011, 16'hF0F0, 16'hFF00, 1'b0}, '{3'b100, 16'hF0F0, 16'hFF00, 1'b0},
      '{3'b111, 16'hF0F0, 16'hFF00, 1'b1}, '{3'b010, 16'hFFFF, 16'h0001, 1'b1},
      '{3'b101, 16'h8000, 16'h0001, 1'b0}
    };
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 send(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].ci);
    end
    @(posedge clk); #1 in_valid = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL ops_drain: %0d results pending, expected 0", sb.size()); end
  endtask
  task automatic test_back_to_back;
    logic [11:0] hist = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 8) send(3'b010, 16'($urandom), 16'($urandom), 1'($urandom));
      else in_valid = 0;
      @(negedge clk);
      hist[c] = out_valid;
    end
    n_checks++;
    if (hist !== 12'b0011_1111_1100) begin
      n_fail++;
      $display("FAIL back_to_back_valid: out_valid history %b expected 001111111100", hist);
    end
  endtask
  task automatic test_stall;
    int idx = 0;
    logic [19:0] snap = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      out_ready = c >= 4;
      if (idx < 3) send(idx == 1 ? 3'b101 : 3'b010, 16'(16'h1111 * (idx + 1)), 16'h0101, 1'b1);
      else in_valid = 0;
      @(negedge clk);
      if (c == 2) snap = {result, c_out, zero, negative, overflow};
      if (c == 3) begin
        n_checks++;
        if (idx != 2) begin n_fail++; $display("FAIL stall_accepts: %0d accepted expected 2", idx); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if ({out_valid, result, c_out, zero, negative, overflow} !== {1'b1, snap}) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid,
                   {result, c_out, zero, negative, overflow}, snap);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
      end
      if (in_valid && in_ready) idx++;
    end
    n_checks++;
    if (idx != 3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: accepted %0d pending %0d expected 3 and 0", idx, sb.size());
    end
  endtask
  task automatic test_reset_inflight;
    out_ready = 0;
    @(posedge clk); #1 send(3'b010, 16'h0001, 16'h0002, 1'b0);
    @(posedge clk); #1 send(3'b011, 16'h00F0, 16'h0F0F, 1'b0);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL inflight_setup: valid/ready=%b%b expected 10", out_valid, in_ready);
    end
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, result, c_out, zero, negative, overflow, in_ready} !== {21'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL inflight_reset: got v=%b r=%h flags=%b rdy=%b expected v=0 r=0000 flags=0000 rdy=1",
               out_valid, result, {c_out, zero, negative, overflow}, in_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_discard: out_valid=%b expected 0", out_valid); end
  endtask
  task automatic test_widths;
    @(posedge clk); #1;
    v4_in = 1; a4 = 4'hF; b4 = 4'h1;
    v32_in = 1; a32 = 32'h0000_FFFF; b32 = 32'h1;
    @(posedge clk); #1 v4_in = 0; v32_in = 0;
    @(negedge clk);
    n_checks++;
    if ({v4_out, v32_out} !== 2'b00) begin n_fail++; $display("FAIL width_early: v4=%b v32=%b expected 00", v4_out, v32_out); end
    @(negedge clk);
    n_checks++;
    if ({v4_out, r4, v4_c, v4_z, v4_n, v4_v} !== {1'b1, 4'h0, 4'b1100}) begin
      n_fail++;
      $display("FAIL width4_add: got v=%b r=%h cznv=%b expected v=1 r=0 cznv=1100", v4_out, r4, {v4_c, v4_z, v4_n, v4_v});
    end
    n_checks++;
    if ({v32_out, r32, v32_c, v32_z, v32_n, v32_v} !== {1'b1, 32'h0001_0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL width32_add: got v=%b r=%h cznv=%b expected v=1 r=00010000 cznv=0000", v32_out, r32, {v32_c, v32_z, v32_n, v32_v});
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_back_to_back();
    repeat (3) @(posedge clk);
    test_stall();
    test_reset_inflight();
    test_widths();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL final_drain: %0d results pending expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
